// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a DIGITS-wide 7-segment bank.
//
// Ports:
//   i_clock        system clock
//   i_reset        synchronous active-low reset
//   i_load         one-cycle strobe capturing i_value / i_dp_in into the shadow
//   i_value        nibble k drives digit k (digit 0 is rightmost)
//   i_dp_in        decimal point per digit
//   i_hex_mode     1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 blank
//   i_lz_blank     1: suppress leading zeros (digit 0 is never blanked)
//   i_enable       0: all digits dark; scan and load keep running
//   o_a..o_g, o_dp registered segment drives (pin polarity applied)
//   o_an           registered one-hot digit select (pin polarity applied)
//   o_digit_idx    digit currently being scanned
//   o_frame_start  one-cycle pulse after digit_idx wraps to 0
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_load,
  input  logic [4*DIGITS-1:0]         i_value,
  input  logic [DIGITS-1:0]           i_dp_in,
  input  logic                        i_hex_mode,
  input  logic                        i_lz_blank,
  input  logic                        i_enable,
  output logic                        o_a,
  output logic                        o_b,
  output logic                        o_c,
  output logic                        o_d,
  output logic                        o_e,
  output logic                        o_f,
  output logic                        o_g,
  output logic                        o_dp,
  output logic [DIGITS-1:0]           o_an,
  output logic [$clog2(DIGITS)-1:0]   o_digit_idx,
  output logic                        o_frame_start
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned PsW  = $clog2(PRESCALE);

  logic [PsW-1:0]      r_presc;
  logic [IdxW-1:0]     r_idx;
  logic                r_frame_start;
  logic [4*DIGITS-1:0] r_shadow_val;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [4*DIGITS-1:0] r_disp_val;
  logic [DIGITS-1:0]   r_disp_dp;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_boundary;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_blank_sel;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_onehot;
  logic [6:0]          w_seg;

  assign w_tick     = (r_presc == PsW'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_idx == IdxW'(DIGITS - 1));

  // Digit k is a leading zero when it and every nibble above it are zero.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_disp_val[4*k +: 4] == 4'h0);
      w_blank[k] = (k != 0) && w_zero_run;
    end
  end

  // Select the nibble, dp and blank flag of the digit being scanned.
  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_onehot    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IdxW'(k)) begin
        w_nib       = r_disp_val[4*k +: 4];
        w_dp_sel    = r_disp_dp[k];
        w_blank_sel = w_blank[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Active-high decode, bit 6 = a ... bit 0 = g.
  always_comb begin
    w_seg = 7'b0000000;
    case (w_nib)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1110011;
      4'hA: w_seg = i_hex_mode ? 7'b1110111 : 7'b0000000;
      4'hB: w_seg = i_hex_mode ? 7'b0011111 : 7'b0000000;
      4'hC: w_seg = i_hex_mode ? 7'b1001110 : 7'b0000000;
      4'hD: w_seg = i_hex_mode ? 7'b0111101 : 7'b0000000;
      4'hE: w_seg = i_hex_mode ? 7'b1001111 : 7'b0000000;
      4'hF: w_seg = i_hex_mode ? 7'b1000111 : 7'b0000000;
      default: w_seg = 7'b0000000;
    endcase
    if (i_lz_blank && w_blank_sel) begin
      w_seg = 7'b0000000;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      r_shadow_val  <= '0;
      r_shadow_dp   <= '0;
      r_disp_val    <= '0;
      r_disp_dp     <= '0;
      r_seg         <= {7{SEG_ACTIVE_LOW}};
      r_dp          <= SEG_ACTIVE_LOW;
      r_an          <= {DIGITS{AN_ACTIVE_LOW}};
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PsW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
      end
      r_frame_start <= w_boundary;
      if (i_load) begin
        r_shadow_val <= i_value;
        r_shadow_dp  <= i_dp_in;
      end
      // A load landing on the boundary tick bypasses the shadow.
      if (w_boundary) begin
        r_disp_val <= i_load ? i_value : r_shadow_val;
        r_disp_dp  <= i_load ? i_dp_in : r_shadow_dp;
      end
      r_seg <= (i_enable ? w_seg : 7'b0000000) ^ {7{SEG_ACTIVE_LOW}};
      r_dp  <= (i_enable && w_dp_sel) ^ SEG_ACTIVE_LOW;
      r_an  <= (i_enable ? w_onehot : '0) ^ {DIGITS{AN_ACTIVE_LOW}};
    end
  end

  assign {o_a, o_b, o_c, o_d, o_e, o_f, o_g} = r_seg;
  assign o_dp          = r_dp;
  assign o_an          = r_an;
  assign o_digit_idx   = r_idx;
  assign o_frame_start = r_frame_start;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment bank; next generation of the single-digit decoder.
- Adds a refresh prescaler, digit scanning, frame-aligned value update with a load strobe, hex mode, leading-zero blanking, per-digit decimal points and a global enable.
- Sits between the datapath (counters, ALU results) and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
PRESCALE, 50000, clock cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 0, 1 inverts a..g and dp at the pins
AN_ACTIVE_LOW, 1, 1 makes anode selects active-low

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
load  in  1  one-cycle strobe: capture value/dp_in
value  in  4*DIGITS  nibble k = digit k; digit 0 is rightmost
dp_in  in  DIGITS  decimal point per digit
hex_mode  in  1  1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 blank
lz_blank  in  1  1: suppress leading zeros
enable  in  1  0: all digits dark
a,b,c,d,e,f,g,dp  out  1 each  segment drives (registered)
an  out  DIGITS  one-hot digit select (registered)
digit_idx  out  clog2(DIGITS)  digit currently being driven
frame_start  out  1  one-cycle pulse when digit_idx wraps to 0

Behaviour:
- Reset (reset=0 at a clock edge): prescaler=0, digit_idx=0, shadow and display registers=0, dp registers=0, frame_start=0, segments at the inactive level, an all inactive. Reset wins over every other input in that cycle.
- Prescaler: counts 0..PRESCALE-1 and wraps. On the wrap cycle (tick), digit_idx <= (digit_idx==DIGITS-1) ? 0 : digit_idx+1.
- frame_start: registered, high for exactly one cycle after the tick that moves digit_idx from DIGITS-1 to 0.
- Load: on load=1, shadow <= {value, dp_in}. Display registers copy shadow only at frame boundaries (the tick with digit_idx==DIGITS-1).
- If load and a frame-boundary tick occur in the same cycle, display takes the newly loaded value (bypass).
- Multiple loads within one frame: the last one wins. No tearing within a frame.
- Decode, active-high segment order a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
  - hex_mode=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - hex_mode=0: codes 10-15 give 0000000.
- Leading-zero blanking (lz_blank=1): digit k is blanked if its nibble and every nibble above it are 0. Digit 0 is never blanked, so 0 shows as a single "0". dp is unaffected by blanking.
- hex_mode and lz_blank are sampled combinationally every cycle and are not frame-aligned.
- Output stage:
  - Each cycle: an <= onehot(digit_idx), segments <= decode(display nibble[digit_idx]), dp <= display dp[digit_idx].
  - Latency: pins reflect digit_idx one cycle after it changes.
  - Polarity parameters are applied last.
- enable=0: an all inactive, segments inactive on the next edge. Prescaler, scan and load keep running. Re-enabling resumes at the current digit_idx.
- Reset mid-frame: scan restarts at digit 0 with display=0. A load in the reset cycle is discarded.

Test Plan (DIGITS=4, PRESCALE=4, active-high segments, AN_ACTIVE_LOW=1):
- Reset, then idle 20 cycles:
  - digit_idx sequence 0,1,2,3,0 with 4 cycles per slot.
  - frame_start pulses every 16 cycles.
  - an cycles 1110,1101,1011,0111 one cycle after each index change.
  - all digits show 1111110.
- load value=0x1234, dp_in=0001 mid-frame:
  - display stays 0 until the next frame boundary.
  - Then digit0 shows 0110011 with dp=1, digit3 shows 0110000.
- Load coincident with the boundary tick: the new value appears in that same frame (bypass check).
- value=0x00A5, hex_mode=0, lz_blank=1:
  - digits 3 and 2 dark, digit 1 dark (code 10 with hex off), digit 0 shows 1011011.
  - Set hex_mode=1: digit 1 shows 1110111.
- value=0x0000, lz_blank=1: only digit 0 lit with 1111110. Toggle enable=0: an=1111 and segments 0 the next cycle, while digit_idx keeps advancing.
- Assert reset during slot 2 with load=1: digit_idx=0, an=1111, segments 0, and the display shows 0 afterwards.
